// File: rtl/imem_pkg.sv
// Shared types and helpers for the synchronous instruction memory.
//   imem_state_e : load/run FSM states
//   NOP_WORD     : default word returned on invalid or out-of-range fetch
//   imem_index   : maps a fetch pc to a word index plus an out-of-range flag
package imem_pkg;

    typedef enum logic [0:0] {
        IMEM_RUN  = 1'b0,
        IMEM_LOAD = 1'b1
    } imem_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] idx;
        logic        oor;
    } imem_index_t;

    // The range check uses the full word index, so high pc bits beyond the
    // RAM's address width still flag a fault instead of aliasing.
    function automatic imem_index_t imem_index(input logic [31:0] pc,
                                               input bit byte_addr,
                                               input int unsigned depth);
        imem_index_t r;
        r.idx = byte_addr ? {2'b00, pc[31:2]} : pc;
        r.oor = (r.idx >= depth);
        return r;
    endfunction

endpackage

// File: rtl/instr_mem_sync_if.sv
// Fetch and program-load bus of the instruction memory.
//   fetch : pc, fetch_en, stall -> instr, instr_valid, fetch_fault (, par_err)
//   load  : ld_start, ld_valid, ld_data, ld_last -> ld_ready, ld_done, ld_count
// Modport master drives requests (IF stage / loader), slave is the memory.
// Optional macro IMEM_PARITY_EN adds the par_err signal.
interface instr_mem_sync_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 11
);
    logic [31:0]       pc;
    logic              fetch_en;
    logic              stall;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              fetch_fault;
`ifdef IMEM_PARITY_EN
    logic              par_err;
`endif
    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_done;
    logic [ADDR_W:0]   ld_count;

    modport master (
        output pc, fetch_en, stall, ld_start, ld_valid, ld_data, ld_last,
        input  instr, instr_valid, fetch_fault, ld_ready, ld_done, ld_count
`ifdef IMEM_PARITY_EN
        , input par_err
`endif
    );

    modport slave (
        input  pc, fetch_en, stall, ld_start, ld_valid, ld_data, ld_last,
        output instr, instr_valid, fetch_fault, ld_ready, ld_done, ld_count
`ifdef IMEM_PARITY_EN
        , output par_err
`endif
    );
endinterface

// File: rtl/imem_ram.sv
// Single-port synchronous RAM: write port plus registered read port.
//   clk, reset : clock, async active-high reset (read register only)
//   we, re     : write / read enable (never both in the same cycle)
//   addr       : shared word address
//   wdata      : write data
//   rdata      : registered read data, holds when re is low
//   par_ok     : (IMEM_PARITY_EN) stored even-parity check of rdata passes
// Contents are not reset.
module imem_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
`ifdef IMEM_PARITY_EN
    ,
    output logic              par_ok
`endif
);
`ifdef IMEM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0] mem [DEPTH];
    logic [MEM_W-1:0] rword_q;
    logic [MEM_W-1:0] wword;

`ifdef IMEM_PARITY_EN
    // Parity bit makes the XOR of the whole stored word zero.
    assign wword  = {^wdata, wdata};
    assign par_ok = ~(^rword_q);
`else
    assign wword  = wdata;
`endif
    assign rdata = rword_q[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wword;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rword_q <= '0;
        end else if (re) begin
            rword_q <= mem[addr];
        end
    end

endmodule

// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory for the IF stage.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : instr_mem_sync_if.slave (fetch port and program-load port)
// RUN serves one-cycle fetches with stall hold; LOAD streams the program in.
// Out-of-range fetches return NOP_WORD with fetch_fault set.
// Optional macro IMEM_PARITY_EN: per-word even parity, par_err output.
module instr_mem_sync
    import imem_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 2048,
    parameter int unsigned       ADDR_W    = $clog2(DEPTH),
    parameter int unsigned       BYTE_ADDR = 0,
    parameter logic [DATA_W-1:0] NOP_WORD  = imem_pkg::NOP_WORD
) (
    input logic           clk,
    input logic           reset,
    instr_mem_sync_if.slave bus
);
    imem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    // Set when instr should come from the RAM read register, else NOP_WORD.
    logic              src_q, src_d;
    logic              we, re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] rdata;
    logic              par_ok;
    imem_index_t       fidx;

    assign fidx     = imem_index(bus.pc, BYTE_ADDR != 0, DEPTH);
    assign ram_addr = we ? wptr_q : fidx.idx[ADDR_W-1:0];

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        fault_d = fault_q;
        src_d   = src_q;
        we      = 1'b0;
        re      = 1'b0;
        unique case (state_q)
            IMEM_RUN: begin
                if (bus.ld_start) begin
                    state_d = IMEM_LOAD;
                    wptr_d  = '0;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    fault_d = 1'b0;
                    src_d   = 1'b0;
                end else if (!bus.stall) begin
                    if (bus.fetch_en) begin
                        valid_d = 1'b1;
                        fault_d = fidx.oor;
                        src_d   = ~fidx.oor;
                        re      = ~fidx.oor;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            IMEM_LOAD: begin
                // ld_ready is constant high in LOAD, so ld_valid is the handshake.
                if (bus.ld_valid) begin
                    we     = 1'b1;
                    wptr_d = wptr_q + ADDR_W'(1);
                    cnt_d  = cnt_q + (ADDR_W + 1)'(1);
                    if (bus.ld_last || wptr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = IMEM_RUN;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IMEM_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IMEM_RUN;
            wptr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            src_q   <= src_d;
        end
    end

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .re     (re),
        .addr   (ram_addr),
        .wdata  (bus.ld_data),
        .rdata  (rdata)
`ifdef IMEM_PARITY_EN
        ,
        .par_ok (par_ok)
`endif
    );

`ifdef IMEM_PARITY_EN
    assign bus.par_err = src_q & ~par_ok;
`else
    assign par_ok = 1'b1;
`endif

    assign bus.instr       = (src_q && par_ok) ? rdata : NOP_WORD;
    assign bus.instr_valid = valid_q;
    assign bus.fetch_fault = fault_q;
    assign bus.ld_ready    = (state_q == IMEM_LOAD);
    assign bus.ld_done     = done_q;
    assign bus.ld_count    = cnt_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Self-checking bench for instr_mem_sync: DUT A (word-addressed) and
// DUT B (byte-addressed), both DEPTH=16, sharing clock and reset.
module tb_instr_mem_sync;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_mem_sync_if #(.DATA_W(32), .ADDR_W(ADDR_W)) bus_a ();
    instr_mem_sync_if #(.DATA_W(32), .ADDR_W(ADDR_W)) bus_b ();

    instr_mem_sync #(.DATA_W(32), .DEPTH(DEPTH), .BYTE_ADDR(0)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    instr_mem_sync #(.DATA_W(32), .DEPTH(DEPTH), .BYTE_ADDR(1)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    typedef struct {
        bit          dut_b;
        logic [31:0] pc;
        logic        fe;
        logic        st;
        logic [31:0] exp_instr;
        logic        exp_valid;
        logic        exp_fault;
    } vec_t;

    vec_t vecs [0:22];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input bit b, input logic [31:0] pc, input logic fe,
                           input logic st, input logic [31:0] ei, input logic ev,
                           input logic ef);
        vecs[i].dut_b     = b;
        vecs[i].pc        = pc;
        vecs[i].fe        = fe;
        vecs[i].st        = st;
        vecs[i].exp_instr = ei;
        vecs[i].exp_valid = ev;
        vecs[i].exp_fault = ef;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].dut_b) begin
                bus_b.pc = vecs[i].pc; bus_b.fetch_en = vecs[i].fe; bus_b.stall = vecs[i].st;
                bus_a.fetch_en = 1'b0; bus_a.stall = 1'b0;
            end else begin
                bus_a.pc = vecs[i].pc; bus_a.fetch_en = vecs[i].fe; bus_a.stall = vecs[i].st;
                bus_b.fetch_en = 1'b0; bus_b.stall = 1'b0;
            end
            step();
            if (vecs[i].dut_b) begin
                check($sformatf("v%0d instr", i), bus_b.instr, vecs[i].exp_instr);
                check($sformatf("v%0d valid", i), 32'(bus_b.instr_valid), 32'(vecs[i].exp_valid));
                check($sformatf("v%0d fault", i), 32'(bus_b.fetch_fault), 32'(vecs[i].exp_fault));
            end else begin
                check($sformatf("v%0d instr", i), bus_a.instr, vecs[i].exp_instr);
                check($sformatf("v%0d valid", i), 32'(bus_a.instr_valid), 32'(vecs[i].exp_valid));
                check($sformatf("v%0d fault", i), 32'(bus_a.fetch_fault), 32'(vecs[i].exp_fault));
            end
        end
        bus_a.fetch_en = 1'b0; bus_a.stall = 1'b0;
        bus_b.fetch_en = 1'b0; bus_b.stall = 1'b0;
    endtask

    logic [31:0] prog3 [3];

    initial begin
        prog3[0] = 32'h8E11_0000;
        prog3[1] = 32'h8E12_0009;
        prog3[2] = 32'h0232_9824;

        // After the 3-word load (pc=0 fetched by hand during ld_done)
        set_vec(0,  0, 32'd1, 1, 0, 32'h8E12_0009, 1, 0);
        set_vec(1,  0, 32'd2, 1, 0, 32'h0232_9824, 1, 0);
        set_vec(2,  0, 32'd7, 0, 0, 32'h0232_9824, 0, 0);
        set_vec(3,  0, 32'd1, 1, 0, 32'h8E12_0009, 1, 0);
        // After the full-depth load of A000_0000 + i
        set_vec(4,  0, 32'd0, 1, 0, 32'hA000_0000, 1, 0);
        set_vec(5,  0, 32'd5, 1, 0, 32'hA000_0005, 1, 0);
        set_vec(6,  0, 32'd9, 1, 1, 32'hA000_0005, 1, 0);
        set_vec(7,  0, 32'd9, 1, 1, 32'hA000_0005, 1, 0);
        set_vec(8,  0, 32'd9, 0, 1, 32'hA000_0005, 1, 0);
        set_vec(9,  0, 32'd6, 1, 0, 32'hA000_0006, 1, 0);
        set_vec(10, 0, 32'd15, 1, 0, 32'hA000_000F, 1, 0);
        set_vec(11, 0, 32'd16, 1, 0, NOP, 1, 1);
        set_vec(12, 0, 32'hFFFF_FFFF, 1, 0, NOP, 1, 1);
        set_vec(13, 0, 32'd3, 1, 1, NOP, 1, 1);
        set_vec(14, 0, 32'd0, 1, 0, 32'hA000_0000, 1, 0);
        // After reset in the middle of a load of C000_000x
        set_vec(15, 0, 32'd0, 1, 0, 32'hC000_0000, 1, 0);
        set_vec(16, 0, 32'd1, 1, 0, 32'hC000_0001, 1, 0);
        set_vec(17, 0, 32'd2, 1, 0, 32'hA000_0002, 1, 0);
        // Byte-addressed DUT, loaded with B000_000x
        set_vec(18, 1, 32'h8,  1, 0, 32'hB000_0002, 1, 0);
        set_vec(19, 1, 32'hB,  1, 0, 32'hB000_0002, 1, 0);
        set_vec(20, 1, 32'h4,  1, 0, 32'hB000_0001, 1, 0);
        set_vec(21, 1, 32'h40, 1, 0, NOP, 1, 1);
        set_vec(22, 1, 32'hC,  1, 0, 32'hB000_0003, 1, 0);

        bus_a.pc = '0; bus_a.fetch_en = 0; bus_a.stall = 0;
        bus_a.ld_start = 0; bus_a.ld_valid = 0; bus_a.ld_data = '0; bus_a.ld_last = 0;
        bus_b.pc = '0; bus_b.fetch_en = 0; bus_b.stall = 0;
        bus_b.ld_start = 0; bus_b.ld_valid = 0; bus_b.ld_data = '0; bus_b.ld_last = 0;

        // Reset state
        step();
        step();
        check("rst instr", bus_a.instr, NOP);
        check("rst valid", 32'(bus_a.instr_valid), 0);
        check("rst fault", 32'(bus_a.fetch_fault), 0);
        check("rst ld_ready", 32'(bus_a.ld_ready), 0);
        check("rst ld_done", 32'(bus_a.ld_done), 0);
        check("rst ld_count", 32'(bus_a.ld_count), 0);
        reset = 1'b0;
        step();

        // Three-word load with ld_last on the third
        bus_a.ld_start = 1;
        step();
        bus_a.ld_start = 0;
        check("load3 ready", 32'(bus_a.ld_ready), 1);
        for (int i = 0; i < 3; i++) begin
            bus_a.ld_valid = 1; bus_a.ld_data = prog3[i]; bus_a.ld_last = (i == 2);
            step();
        end
        bus_a.ld_valid = 0; bus_a.ld_last = 0;
        check("load3 done", 32'(bus_a.ld_done), 1);
        check("load3 count", 32'(bus_a.ld_count), 3);
        check("load3 ready off", 32'(bus_a.ld_ready), 0);
        // A fetch is accepted in the ld_done cycle
        bus_a.pc = 0; bus_a.fetch_en = 1;
        step();
        bus_a.fetch_en = 0;
        check("load3 done pulse", 32'(bus_a.ld_done), 0);
        check("fetch0 instr", bus_a.instr, prog3[0]);
        check("fetch0 valid", 32'(bus_a.instr_valid), 1);
        run_vecs(0, 3);

        // Full-depth load without ld_last; ld_start with a fetch drops valid
        bus_a.ld_start = 1; bus_a.fetch_en = 1; bus_a.pc = 2;
        step();
        bus_a.ld_start = 0; bus_a.fetch_en = 0;
        check("full start valid", 32'(bus_a.instr_valid), 0);
        check("full start instr", bus_a.instr, NOP);
        check("full start count", 32'(bus_a.ld_count), 0);
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            bus_a.ld_valid = 1; bus_a.ld_data = 32'hA000_0000 + 32'(i);
            if (i == 0) check("full ready", 32'(bus_a.ld_ready), 1);
            if (i >= int'(DEPTH)) check($sformatf("extra%0d ready", i), 32'(bus_a.ld_ready), 0);
            step();
            if (i == int'(DEPTH) - 1) begin
                check("full done", 32'(bus_a.ld_done), 1);
                check("full count", 32'(bus_a.ld_count), DEPTH);
            end
            if (i == int'(DEPTH)) begin
                check("full done pulse", 32'(bus_a.ld_done), 0);
                check("full count hold", 32'(bus_a.ld_count), DEPTH);
            end
        end
        bus_a.ld_valid = 0;
        run_vecs(4, 14);

        // Reset after two of four load words
        bus_a.ld_start = 1;
        step();
        bus_a.ld_start = 0;
        for (int i = 0; i < 2; i++) begin
            bus_a.ld_valid = 1; bus_a.ld_data = 32'hC000_0000 + 32'(i);
            step();
        end
        check("midrst count pre", 32'(bus_a.ld_count), 2);
        bus_a.ld_data = 32'hC000_0002;
        #2 reset = 1'b1;
        #1;
        check("midrst ready", 32'(bus_a.ld_ready), 0);
        check("midrst count", 32'(bus_a.ld_count), 0);
        bus_a.ld_valid = 0;
        step();
        reset = 1'b0;
        step();
        check("midrst ready after", 32'(bus_a.ld_ready), 0);
        run_vecs(15, 17);

`ifdef IMEM_PARITY_EN
        u_dut_a.u_ram.mem[1] = u_dut_a.u_ram.mem[1] ^ 33'h1;
        bus_a.pc = 1; bus_a.fetch_en = 1;
        step();
        check("par flip instr", bus_a.instr, NOP);
        check("par flip err", 32'(bus_a.par_err), 1);
        bus_a.pc = 0;
        step();
        bus_a.fetch_en = 0;
        check("par ok instr", bus_a.instr, 32'hC000_0000);
        check("par ok err", 32'(bus_a.par_err), 0);
`endif

        // Byte-addressed DUT
        bus_b.ld_start = 1;
        step();
        bus_b.ld_start = 0;
        for (int i = 0; i < 4; i++) begin
            bus_b.ld_valid = 1; bus_b.ld_data = 32'hB000_0000 + 32'(i); bus_b.ld_last = (i == 3);
            step();
        end
        bus_b.ld_valid = 0; bus_b.ld_last = 0;
        check("b done", 32'(bus_b.ld_done), 1);
        check("b count", 32'(bus_b.ld_count), 4);
        run_vecs(18, 22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_mem_sync.md
# instr_mem_sync

Parametrised, synchronous-read instruction memory for the MIPS pipeline's IF stage, replacing the hard-coded combinational program store. The program is streamed in at run time through a load handshake, fetches have one-cycle latency with stall hold, and out-of-range PCs return a NOP and a fault flag instead of undefined data.

## Interface
- DATA_W, 32, instruction width in bits
- DEPTH, 2048, number of instruction words
- ADDR_W, $clog2(DEPTH), internal word-index width
- BYTE_ADDR, 0, 0 = `pc` is a word index; 1 = `pc` is a byte address, word index = `pc[ADDR_W+1:2]`, `pc[1:0]` ignored
- NOP_WORD, 32'h0000_0000, value driven on invalid or out-of-range fetch
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- pc  in  32  fetch address
- fetch_en  in  1  request a fetch at `pc` this cycle
- stall  in  1  hold the fetch outputs and ignore `fetch_en`
- instr  out  DATA_W  fetched instruction
- instr_valid  out  1  `instr` holds a completed fetch
- fetch_fault  out  1  last fetch address was at or beyond DEPTH
- ld_start  in  1  begin a program load; write pointer goes to 0
- ld_valid  in  1  `ld_data` is valid
- ld_data  in  DATA_W  program word
- ld_last  in  1  marks the final word
- ld_ready  out  1  block accepts `ld_data` (high in LOAD)
- ld_done  out  1  one-cycle pulse when a load completes
- ld_count  out  ADDR_W+1  words written by the current or last load

## Operation
- FSM states: RUN and LOAD. Reset enters RUN.
- RUN: on `ld_start`, go to LOAD, clear the write pointer and `ld_count`, and drop `instr_valid` on the next edge.
- LOAD: on each cycle with `ld_valid & ld_ready`, write `mem[wptr] <= ld_data`, then increment `wptr` and `ld_count`.
- LOAD exit: a handshake with `ld_last`, or a write to index DEPTH-1, returns the FSM to RUN and pulses `ld_done`. The pointer does not wrap; nothing is written past DEPTH-1.
- In LOAD, `ld_start` is ignored and `fetch_en` is ignored. Fetch outputs are `instr`=NOP_WORD, `instr_valid`=0 and `fetch_fault`=0.
- Fetch in RUN with `fetch_en & ~stall`, one registered read:
  - index in range: `instr <= mem[index]`, `instr_valid <= 1`, `fetch_fault <= 0`;
  - index ≥ DEPTH, judged on the full `pc` (or `pc[31:2]` when BYTE_ADDR=1): `instr <= NOP_WORD`, `instr_valid <= 1`, `fetch_fault <= 1`.
- RUN with `~fetch_en & ~stall`: `instr_valid <= 0`, `instr` and `fetch_fault` hold.
- `stall`=1: all fetch outputs hold their values, and stall takes priority over `fetch_en`.
- Memory contents are not cleared by reset. Only a load changes them.

## Timing
- Fetch latency: 1 cycle. `pc` sampled at edge N gives `instr` valid after edge N.
- Load throughput: one word per cycle, with `ld_ready` high for every cycle in LOAD.
- RUN→LOAD on the edge that samples `ld_start`, so `ld_ready` is high in the following cycle.
- LOAD→RUN on the edge of the final write, with `ld_done` high for exactly the next cycle. A fetch is accepted in that same cycle.
- Reset values: `instr`=NOP_WORD, `instr_valid`=0, `fetch_fault`=0, `ld_ready`=0, `ld_done`=0, `ld_count`=0, FSM=RUN, `wptr`=0.
- Reset asserted mid-load: the FSM returns to RUN immediately. Words already written persist, and `ld_count` clears.

## Configuration
- IMEM_PARITY_EN, when defined:
  - each stored word carries an even-parity bit computed at write;
  - every in-range fetch recomputes parity and registers the result on output `par_err` (1 bit, reset 0, same timing as `instr`);
  - a word that fails the check is replaced by NOP_WORD.
- When undefined: no parity storage, no `par_err` port.

## Structure
- Shared package `imem_pkg` holds:
  - the FSM state enum (`IMEM_RUN`, `IMEM_LOAD`);
  - the default `NOP_WORD` constant;
  - the `imem_index` function that maps `pc` to a word index plus an out-of-range flag under BYTE_ADDR.
- One sub-module, `imem_ram`: a single-port synchronous RAM (write port plus registered read port, optional parity bit). The top level contains the FSM, fetch control and hold logic.

## Test plan
- Reset, then load words 0x8E11_0000, 0x8E12_0009, 0x0232_9824 with `ld_last` on the third → `ld_done` pulses one cycle after the third write and `ld_count`=3. Fetching pc=0,1,2 then returns those words one cycle later, each with `instr_valid`=1.
- Fetch pc=5 with `stall` raised in the cycle after → `instr` and `instr_valid` hold for every stall cycle. Releasing `stall` with pc=6 returns `mem[6]` next cycle.
- Fetch pc=DEPTH, then pc=0xFFFF_FFFF → `instr`=NOP_WORD with `fetch_fault`=1 for both. A next fetch of pc=0 clears `fetch_fault`.
- BYTE_ADDR=1: fetch pc=0x8, then pc=0xB → both return `mem[2]`.
- Load DEPTH+2 words without `ld_last` → exit after word DEPTH-1, `ld_count`=DEPTH. The extra words see `ld_ready`=0 and `mem[0]` is unchanged.
- Assert `reset` after 2 of 4 load words → FSM=RUN and `ld_count`=0, while fetching pc=0,1 still returns the two loaded words. With IMEM_PARITY_EN, forcing a bit flip in `mem[1]` gives `par_err`=1 and `instr`=NOP_WORD.
